// File: rtl/setpoint_pkg.sv
// Shared definitions for the oven-timer setpoint entry block: BCD digit
// widths, setpoint limits and the push-button state machine encoding.
// SETPOINT_AUTO_REPEAT_EN adds the hold-to-repeat states.
package setpoint_pkg;

    localparam int SEC_ONES_W = 4;
    localparam int SEC_TENS_W = 3;
    localparam int MIN_ONES_W = 4;
    localparam int MIN_TENS_W = 3;

    localparam logic [SEC_TENS_W-1:0] MAX_SEC_TENS = 3'd5;
    localparam logic [MIN_TENS_W-1:0] MAX_MIN_TENS = 3'd5;
    localparam logic [MIN_ONES_W-1:0] MAX_MIN_ONES = 4'd9;
    localparam logic [SEC_ONES_W-1:0] STEP_SEC     = 4'd5;

`ifdef SETPOINT_AUTO_REPEAT_EN
    typedef enum logic [1:0] {
        BTN_IDLE   = 2'd0,
        BTN_FIRST  = 2'd1,
        BTN_DELAY  = 2'd2,
        BTN_REPEAT = 2'd3
    } btn_state_t;
`else
    typedef enum logic [1:0] {
        BTN_IDLE  = 2'd0,
        BTN_FIRST = 2'd1,
        BTN_HELD  = 2'd2
    } btn_state_t;
`endif

endpackage

// File: rtl/setpoint_entry_button_conditioner.sv
// One push-button channel: 2-flop synchroniser, debounce filter, press FSM
// and (with SETPOINT_AUTO_REPEAT_EN) hold-to-repeat. Emits the clean
// pressed level and a one-cycle registered step request.
module button_conditioner
    import setpoint_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
`ifdef SETPOINT_AUTO_REPEAT_EN
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
`endif
    parameter int CNT_W           = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_n,
    input  logic hold_idle,
    output logic pressed,
    output logic step_req
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             clean_r;
    logic             clean_d_r;
    logic [CNT_W-1:0] db_cnt_r;
    btn_state_t       state_r;
    btn_state_t       state_next_s;
    logic             step_req_r;
    logic             step_next_s;
    logic             press_edge_s;

`ifdef SETPOINT_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    logic [CNT_W-1:0] rep_cnt_r;
    logic [CNT_W-1:0] rep_next_s;
`endif

    // clean_r is the released(1)/pressed(0) level; pressed is its inverse
    assign pressed      = ~clean_r;
    assign press_edge_s = ~clean_r & clean_d_r;
    assign step_req     = step_req_r;

    // Synchronise the raw level and accept it only after it has been stable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r   <= 1'b1;
            sync2_r   <= 1'b1;
            clean_r   <= 1'b1;
            clean_d_r <= 1'b1;
            db_cnt_r  <= '0;
        end else begin
            sync1_r   <= button_n;
            sync2_r   <= sync1_r;
            clean_d_r <= clean_r;
            if (sync2_r == clean_r) begin
                db_cnt_r <= '0;
            end else if (db_cnt_r == DB_LAST) begin
                clean_r  <= sync2_r;
                db_cnt_r <= '0;
            end else begin
                db_cnt_r <= db_cnt_r + 1'b1;
            end
        end
    end

    // Press FSM next state and step request; release or inhibit forces IDLE
    always_comb begin
        state_next_s = state_r;
        step_next_s  = 1'b0;
`ifdef SETPOINT_AUTO_REPEAT_EN
        rep_next_s   = rep_cnt_r;
`endif
        if (hold_idle || clean_r) begin
            state_next_s = BTN_IDLE;
        end else begin
            case (state_r)
                BTN_IDLE: begin
                    if (press_edge_s) begin
                        state_next_s = BTN_FIRST;
                        step_next_s  = 1'b1;
`ifdef SETPOINT_AUTO_REPEAT_EN
                        rep_next_s   = '0;
`endif
                    end else begin
                        state_next_s = BTN_IDLE;
                    end
                end
`ifdef SETPOINT_AUTO_REPEAT_EN
                // the delay is timed from the first step, so FIRST counts too
                BTN_FIRST: begin
                    state_next_s = BTN_DELAY;
                    rep_next_s   = rep_cnt_r + 1'b1;
                end
                BTN_DELAY: begin
                    if (rep_cnt_r == DLY_LAST) begin
                        state_next_s = BTN_REPEAT;
                        step_next_s  = 1'b1;
                        rep_next_s   = '0;
                    end else begin
                        rep_next_s   = rep_cnt_r + 1'b1;
                    end
                end
                BTN_REPEAT: begin
                    if (rep_cnt_r == PER_LAST) begin
                        step_next_s = 1'b1;
                        rep_next_s  = '0;
                    end else begin
                        rep_next_s  = rep_cnt_r + 1'b1;
                    end
                end
`else
                BTN_FIRST: state_next_s = BTN_HELD;
                BTN_HELD:  state_next_s = BTN_HELD;
`endif
                default: state_next_s = BTN_IDLE;
            endcase
        end
    end

    // FSM state, repeat counter and registered step request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= BTN_IDLE;
            step_req_r <= 1'b0;
`ifdef SETPOINT_AUTO_REPEAT_EN
            rep_cnt_r  <= '0;
`endif
        end else begin
            state_r    <= state_next_s;
            step_req_r <= step_next_s;
`ifdef SETPOINT_AUTO_REPEAT_EN
            rep_cnt_r  <= rep_next_s;
`endif
        end
    end

endmodule

// File: rtl/setpoint_entry.sv
// Oven-timer setpoint entry: two conditioned buttons step a BCD mm:ss
// setpoint in 5 s increments (saturating 00:00..59:55); a set->run edge on
// toggle_set issues a one-cycle load strobe to the countdown.
// Optional hold-to-repeat: define SETPOINT_AUTO_REPEAT_EN.
module setpoint_entry
    import setpoint_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W           = 26
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  button_inc_n,
    input  logic                  button_dec_n,
    input  logic                  toggle_set,
    output logic [SEC_ONES_W-1:0] sec_ones,
    output logic [SEC_TENS_W-1:0] sec_tens,
    output logic [MIN_ONES_W-1:0] min_ones,
    output logic [MIN_TENS_W-1:0] min_tens,
    output logic                  load,
    output logic                  step_ack
);

    logic inc_pressed_s, dec_pressed_s, inc_req_s, dec_req_s;
    logic run_mode_s, hold_idle_s;
    logic tog_sync1_r, tog_sync2_r, tog_prev_r, tog_prev_valid_r;
    logic [1:0] tog_fill_r;
    logic load_r, step_ack_r;
    logic [SEC_ONES_W-1:0] sec_ones_r, inc_so_s, dec_so_s;
    logic [SEC_TENS_W-1:0] sec_tens_r, inc_st_s, dec_st_s;
    logic [MIN_ONES_W-1:0] min_ones_r, inc_mo_s, dec_mo_s;
    logic [MIN_TENS_W-1:0] min_tens_r, inc_mt_s, dec_mt_s;

    assign run_mode_s  = tog_sync2_r;
    // pressing both buttons together must never start a repeat
    assign hold_idle_s = run_mode_s | (inc_pressed_s & dec_pressed_s);

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
`ifdef SETPOINT_AUTO_REPEAT_EN
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD),
`endif
        .CNT_W          (CNT_W)
    ) u_inc (
        .clk(clk), .rst_n(rst_n), .button_n(button_inc_n),
        .hold_idle(hold_idle_s), .pressed(inc_pressed_s), .step_req(inc_req_s)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
`ifdef SETPOINT_AUTO_REPEAT_EN
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD),
`endif
        .CNT_W          (CNT_W)
    ) u_dec (
        .clk(clk), .rst_n(rst_n), .button_n(button_dec_n),
        .hold_idle(hold_idle_s), .pressed(dec_pressed_s), .step_req(dec_req_s)
    );

    // Synchronise the mode switch; arm edge detection only once the
    // synchroniser holds a real sample, so a switch already high at reset
    // release does not look like a set->run edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tog_sync1_r      <= 1'b0;
            tog_sync2_r      <= 1'b0;
            tog_prev_r       <= 1'b0;
            tog_fill_r       <= 2'b00;
            tog_prev_valid_r <= 1'b0;
            load_r           <= 1'b0;
        end else begin
            tog_sync1_r      <= toggle_set;
            tog_sync2_r      <= tog_sync1_r;
            tog_prev_r       <= tog_sync2_r;
            tog_fill_r       <= {tog_fill_r[0], 1'b1};
            tog_prev_valid_r <= tog_fill_r[1];
            load_r           <= tog_prev_valid_r & tog_sync2_r & ~tog_prev_r;
        end
    end

    // Saturating BCD +5 s and -5 s candidates for the current setpoint
    always_comb begin
        inc_so_s = sec_ones_r; inc_st_s = sec_tens_r;
        inc_mo_s = min_ones_r; inc_mt_s = min_tens_r;
        dec_so_s = sec_ones_r; dec_st_s = sec_tens_r;
        dec_mo_s = min_ones_r; dec_mt_s = min_tens_r;
        if ((min_tens_r == MAX_MIN_TENS) && (min_ones_r == MAX_MIN_ONES) &&
            (sec_tens_r == MAX_SEC_TENS) && (sec_ones_r == STEP_SEC)) begin
            inc_so_s = sec_ones_r;
        end else if (sec_ones_r == 4'd0) begin
            inc_so_s = STEP_SEC;
        end else begin
            inc_so_s = 4'd0;
            if (sec_tens_r != MAX_SEC_TENS) begin
                inc_st_s = sec_tens_r + 3'd1;
            end else begin
                inc_st_s = 3'd0;
                if (min_ones_r != MAX_MIN_ONES) begin
                    inc_mo_s = min_ones_r + 4'd1;
                end else begin
                    inc_mo_s = 4'd0;
                    inc_mt_s = min_tens_r + 3'd1;
                end
            end
        end
        if ((min_tens_r == 3'd0) && (min_ones_r == 4'd0) &&
            (sec_tens_r == 3'd0) && (sec_ones_r == 4'd0)) begin
            dec_so_s = sec_ones_r;
        end else if (sec_ones_r == STEP_SEC) begin
            dec_so_s = 4'd0;
        end else begin
            dec_so_s = STEP_SEC;
            if (sec_tens_r != 3'd0) begin
                dec_st_s = sec_tens_r - 3'd1;
            end else begin
                dec_st_s = MAX_SEC_TENS;
                if (min_ones_r != 4'd0) begin
                    dec_mo_s = min_ones_r - 4'd1;
                end else begin
                    dec_mo_s = MAX_MIN_ONES;
                    dec_mt_s = min_tens_r - 3'd1;
                end
            end
        end
    end

    // Apply a single unambiguous step request; simultaneous requests cancel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sec_ones_r <= 4'd0; sec_tens_r <= 3'd0;
            min_ones_r <= 4'd0; min_tens_r <= 3'd0;
            step_ack_r <= 1'b0;
        end else begin
            step_ack_r <= 1'b0;
            if (!run_mode_s && (inc_req_s ^ dec_req_s)) begin
                step_ack_r <= 1'b1;
                if (inc_req_s) begin
                    sec_ones_r <= inc_so_s; sec_tens_r <= inc_st_s;
                    min_ones_r <= inc_mo_s; min_tens_r <= inc_mt_s;
                end else begin
                    sec_ones_r <= dec_so_s; sec_tens_r <= dec_st_s;
                    min_ones_r <= dec_mo_s; min_tens_r <= dec_mt_s;
                end
            end
        end
    end

    assign sec_ones = sec_ones_r;
    assign sec_tens = sec_tens_r;
    assign min_ones = min_ones_r;
    assign min_tens = min_tens_r;
    assign load     = load_r;
    assign step_ack = step_ack_r;

endmodule
